banked_register_file: RTL and testbench
=======================================

// Module: banked_register_file
// PURPOSE
//   Parametrised ARM register file for the pipelined core. Provides NUM_RD combinational read ports and
//   two synchronous write ports: WB result and LDR/STR base writeback. R13/R14 are banked per mode
//   (USR/SVC/IRQ). Same-cycle write-to-read bypass is built in. A per-register busy scoreboard drives
//   decode-stage hazard detection. Sits between the decode stage (reads, issue) and writeback (writes).
// PARAMETERS
//   DATA_W   32  width of every register and data port
//   NUM_RD   3   number of read ports (1..4); port k uses slice [k*4+:4] / [k*DATA_W+:DATA_W]
//   BYPASS   1   1 = read ports see same-cycle write data; 0 = read returns stored value
// PORTS
//   CLK       in   1            clock; all state updates on rising edge
//   Reset     in   1            reset, asynchronous, active-high
//   Mode      in   2            0=USR 1=SVC 2=IRQ 3=reserved (treated as USR)
//   RA        in   4*NUM_RD     read addresses
//   RD        out  DATA_W*NUM_RD read data
//   RBusy     out  NUM_RD       busy flag of each read address (per current Mode bank)
//   R15       in   DATA_W       PC+8 value returned for any read of address 15
//   WE3       in   1            write enable, port 3 (WB result)
//   A3        in   4            write address, port 3
//   WD3       in   DATA_W       write data, port 3
//   WE4       in   1            write enable, port 4 (base writeback)
//   A4        in   4            write address, port 4
//   WD4       in   DATA_W       write data, port 4
//   IssueVal  in   1            instruction issued that will write IssueReg
//   IssueReg  in   4            destination register of issued instruction
//   AnyBusy   out  1            OR of all 19 busy bits
// BEHAVIOUR
//   - Storage: 19 physical entries: R0-R12 shared; R13/R14 x 3 banks (USR,SVC,IRQ). Logical address
//     13/14 maps to the bank selected by Mode at that same cycle, for reads, writes and scoreboard.
//   - Reset (async, any time, including mid-write): all 19 entries = 0 and all busy bits = 0.
//     While Reset is high, RD returns 0, except address 15, which returns R15. RBusy = 0 and AnyBusy = 0.
//   - Write: on posedge CLK, if WEn and An != 15, entry(An) <= WDn. Writes to 15 are silently dropped
//     (PC is owned by fetch).
//   - Write conflict: WE3 & WE4 & A3 == A4 (same bank) -> port 3 data is stored; port 4 is discarded.
//   - Read: combinational, zero latency.
//     - RA == 15 -> R15.
//     - Else if BYPASS and WE3 & A3 == RA -> WD3.
//     - Else if BYPASS and WE4 & A4 == RA -> WD4.
//     - Else stored entry.
//   - Scoreboard, one busy bit per physical entry, updated on posedge CLK:
//     - Set when IssueVal and IssueReg != 15.
//     - Cleared when WE3 or WE4 writes that entry.
//     - Set and clear on the same entry in the same cycle -> set wins (newer producer pending).
//     - IssueReg == 15 never sets a bit.
//     - RBusy[k] is the current (registered) busy bit of RA[k]; a clear takes effect the cycle after the write.
//     - RA == 15 -> RBusy = 0.
//   - Mode change takes effect combinationally; no state is copied between banks. Busy bits of other
//     banks persist and clear normally when written.
//   - Mode == 3 behaves identically to 0.
//   - No X output for any address/mode combination; NUM_RD outside 1..4 is a elaboration error ($error).
// TESTING
//   1. Pulse Reset mid-cycle after writing R3=0x1234 -> RD(R3)=0, AnyBusy=0 immediately, before next edge.
//   2. Write R5=0xDEADBEEF via port 3 while RA0=5 -> RD0=0xDEADBEEF in same cycle with BYPASS=1;
//      previous value with BYPASS=0; stored value is 0xDEADBEEF next cycle.
//   3. WE3 & WE4 both to R7 (WD3=0x11, WD4=0x22) -> R7 reads 0x11 next cycle; WE3 to A3=15 -> RD(15)
//      still equals R15 input.
//   4. Mode=SVC write R13=0x8000; Mode=IRQ write R13=0x9000; Mode=USR read R13 -> 0.
//      SVC -> 0x8000, IRQ -> 0x9000; Mode=3 reads USR value.
//   5. IssueVal R2 -> RBusy(R2)=1 next cycle; WE3 to R2 plus IssueVal R2 same cycle -> stays 1;
//      write R2 alone -> RBusy=0 the cycle after.
//   6. IssueReg=15 -> no busy bit set, AnyBusy stays 0; random R/W/issue vs golden model, 10k cycles, all modes.

Source files
------------

// File: rtl/banked_register_file.sv
//------------------------------------------------------------------------------
// Module   : banked_register_file
// Function : ARM register file, R13/R14 banked per mode, bypassed reads, busy scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module banked_register_file #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [1:0]               Mode,
  input  logic [4*NUM_RD-1:0]      RA,
  output logic [DATA_W*NUM_RD-1:0] RD,
  output logic [NUM_RD-1:0]        RBusy,
  input  logic [DATA_W-1:0]        R15,
  input  logic                     WE3,
  input  logic [3:0]               A3,
  input  logic [DATA_W-1:0]        WD3,
  input  logic                     WE4,
  input  logic [3:0]               A4,
  input  logic [DATA_W-1:0]        WD4,
  input  logic                     IssueVal,
  input  logic [3:0]               IssueReg,
  output logic                     AnyBusy
);

  localparam int         c_NUM_ENT = 19;
  localparam logic [3:0] c_PC_ADDR = 4'd15;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("banked_register_file: NUM_RD must be in 1..4");
  end

  // Physical layout: 0..12 shared, 13/14 USR, 15/16 SVC, 17/18 IRQ (mode 3 aliases USR).
  function automatic logic [4:0] f_phys(input logic [3:0] a, input logic [1:0] m);
    logic [4:0] off;
    case (m)
      2'd1:    off = 5'd2;
      2'd2:    off = 5'd4;
      default: off = 5'd0;
    endcase
    if (a == 4'd13 || a == 4'd14) f_phys = {1'b0, a} + off;
    else                          f_phys = {1'b0, a};
  endfunction

  logic [DATA_W-1:0]    r_regs [c_NUM_ENT];
  logic [c_NUM_ENT-1:0] r_busy;

  logic [4:0]           w_p3;
  logic [4:0]           w_p4;
  logic [4:0]           w_pi;
  logic                 w_wr3;
  logic                 w_wr4;
  logic [c_NUM_ENT-1:0] w_set;
  logic [c_NUM_ENT-1:0] w_clr;

  assign w_p3  = f_phys(A3, Mode);
  assign w_p4  = f_phys(A4, Mode);
  assign w_pi  = f_phys(IssueReg, Mode);
  assign w_wr3 = WE3 && (A3 != c_PC_ADDR);
  assign w_wr4 = WE4 && (A4 != c_PC_ADDR);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (IssueVal && IssueReg != c_PC_ADDR) w_set[w_pi] = 1'b1;
    if (w_wr3) w_clr[w_p3] = 1'b1;
    if (w_wr4) w_clr[w_p4] = 1'b1;
  end

  // Port 3 is assigned last so it wins a same-entry conflict with port 4.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < c_NUM_ENT; i++) r_regs[i] <= '0;
    end else begin
      if (w_wr4) r_regs[w_p4] <= WD4;
      if (w_wr3) r_regs[w_p3] <= WD3;
    end
  end

  // A new issue outranks a completing write on the same entry.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign AnyBusy = |r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [3:0]        w_ra;
    logic [4:0]        w_pr;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = RA[k*4 +: 4];
    assign w_pr = f_phys(w_ra, Mode);

    always_comb begin
      w_rd = r_regs[w_pr];
      if (w_ra == c_PC_ADDR)                   w_rd = R15;
      else if (Reset)                          w_rd = '0;
      else if (BYPASS && WE3 && (A3 == w_ra))  w_rd = WD3;
      else if (BYPASS && WE4 && (A4 == w_ra))  w_rd = WD4;
    end

    assign RD[k*DATA_W +: DATA_W] = w_rd;
    assign RBusy[k]               = (w_ra != c_PC_ADDR) && r_busy[w_pr];
  end

endmodule

`default_nettype wire

// File: tb/tb_banked_register_file.sv
//------------------------------------------------------------------------------
// Module   : tb_banked_register_file
// Function : Directed and random checks of banked_register_file against a mode-bank model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_banked_register_file;

  logic        CLK;
  logic        Reset;
  logic [1:0]  Mode;
  logic [11:0] RA;
  logic [95:0] RD;
  logic [2:0]  RBusy;
  logic [31:0] R15;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        WE4;
  logic [3:0]  A4;
  logic [31:0] WD4;
  logic        IssueVal;
  logic [3:0]  IssueReg;
  logic        AnyBusy;
  logic [31:0] RD2;
  logic        RBusy2;
  logic        AnyBusy2;

  int n_chk  = 0;
  int n_fail = 0;

  banked_register_file #(.DATA_W(32), .NUM_RD(3), .BYPASS(1'b1)) u_dut (
    .CLK(CLK), .Reset(Reset), .Mode(Mode), .RA(RA), .RD(RD), .RBusy(RBusy), .R15(R15),
    .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4),
    .IssueVal(IssueVal), .IssueReg(IssueReg), .AnyBusy(AnyBusy)
  );

  banked_register_file #(.DATA_W(32), .NUM_RD(1), .BYPASS(1'b0)) u_dut_nb (
    .CLK(CLK), .Reset(Reset), .Mode(Mode), .RA(RA[3:0]), .RD(RD2), .RBusy(RBusy2), .R15(R15),
    .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4),
    .IssueVal(IssueVal), .IssueReg(IssueReg), .AnyBusy(AnyBusy2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: shared R0-R12 plus one R13/R14 pair per bank, each with its busy flag.
  logic [31:0] m_gpr [13];
  logic [31:0] m_bnk [3][2];
  logic        m_gb  [13];
  logic        m_bb  [3][2];

  function automatic int bk(input logic [1:0] m);
    return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
  endfunction

  function logic [31:0] m_get(input logic [3:0] a, input logic [1:0] m);
    if (a < 4'd13) return m_gpr[a];
    return m_bnk[bk(m)][a - 4'd13];
  endfunction

  function logic [31:0] m_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd15)                  return R15;
    if (Reset)                       return 32'h0;
    if (byp && WE3 && A3 == a)       return WD3;
    if (byp && WE4 && A4 == a)       return WD4;
    return m_get(a, Mode);
  endfunction

  function logic m_busy(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
    if (a < 4'd13)  return m_gb[a];
    return m_bb[bk(Mode)][a - 4'd13];
  endfunction

  function logic m_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 13; i++) r = r | m_gb[i];
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 2; j++) r = r | m_bb[b][j];
    return r;
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 13; i++) begin
        m_gpr[i] <= 32'h0;
        m_gb[i]  <= 1'b0;
      end
      for (int b = 0; b < 3; b++)
        for (int j = 0; j < 2; j++) begin
          m_bnk[b][j] <= 32'h0;
          m_bb[b][j]  <= 1'b0;
        end
    end else begin
      // Later assignments override earlier ones: port 4, then port 3, then issue.
      if (WE4 && A4 != 4'd15) begin
        if (A4 < 4'd13) begin m_gpr[A4] <= WD4; m_gb[A4] <= 1'b0; end
        else begin m_bnk[bk(Mode)][A4 - 4'd13] <= WD4; m_bb[bk(Mode)][A4 - 4'd13] <= 1'b0; end
      end
      if (WE3 && A3 != 4'd15) begin
        if (A3 < 4'd13) begin m_gpr[A3] <= WD3; m_gb[A3] <= 1'b0; end
        else begin m_bnk[bk(Mode)][A3 - 4'd13] <= WD3; m_bb[bk(Mode)][A3 - 4'd13] <= 1'b0; end
      end
      if (IssueVal && IssueReg != 4'd15) begin
        if (IssueReg < 4'd13) m_gb[IssueReg] <= 1'b1;
        else m_bb[bk(Mode)][IssueReg - 4'd13] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_rd%0d", k), RD[k*32 +: 32], m_rd(RA[k*4 +: 4], 1'b1));
      chk($sformatf("model_rbusy%0d", k), {31'b0, RBusy[k]}, {31'b0, m_busy(RA[k*4 +: 4])});
    end
    chk("model_anybusy", {31'b0, AnyBusy}, {31'b0, m_any()});
    chk("model_rd_nobyp", RD2, m_rd(RA[3:0], 1'b0));
    chk("model_rbusy_nobyp", {31'b0, RBusy2}, {31'b0, m_busy(RA[3:0])});
    chk("model_anybusy_nobyp", {31'b0, AnyBusy2}, {31'b0, m_any()});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; WE4 = 1'b0; IssueVal = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Mode = 2'd0; RA = 12'h000; R15 = 32'h1000_0008;
    WE3 = 1'b0; A3 = 4'd0; WD3 = 32'h0; WE4 = 1'b0; A4 = 4'd0; WD4 = 32'h0;
    IssueVal = 1'b0; IssueReg = 4'd0;
    RA = {4'd3, 4'd0, 4'd15};
    #8;
    chk("reset_r15", RD[31:0], 32'h1000_0008);
    chk("reset_r3", RD[95:64], 32'h0);
    chk("reset_anybusy", {31'b0, AnyBusy}, 32'h0);
    step();
    step();
    Reset = 1'b0;

    // Asynchronous reset in mid-cycle after a write and an issue.
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h1234; IssueVal = 1'b1; IssueReg = 4'd4;
    step();
    idle(); RA = {4'd0, 4'd0, 4'd3};
    #2;
    chk("t1_r3_written", RD[31:0], 32'h1234);
    chk("t1_anybusy_set", {31'b0, AnyBusy}, 32'h1);
    Reset = 1'b1;
    #1;
    chk("t1_r3_after_reset", RD[31:0], 32'h0);
    chk("t1_anybusy_after_reset", {31'b0, AnyBusy}, 32'h0);
    step();
    Reset = 1'b0;

    // Same-cycle bypass vs stored value.
    RA = {4'd0, 4'd0, 4'd5};
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'hDEAD_BEEF;
    #2;
    chk("t2_bypass", RD[31:0], 32'hDEAD_BEEF);
    chk("t2_nobypass", RD2, 32'h0);
    step();
    idle();
    #2;
    chk("t2_stored", RD[31:0], 32'hDEAD_BEEF);
    chk("t2_stored_nobypass", RD2, 32'hDEAD_BEEF);

    // Write conflict and dropped PC write.
    WE3 = 1'b1; A3 = 4'd7; WD3 = 32'h11; WE4 = 1'b1; A4 = 4'd7; WD4 = 32'h22;
    step();
    idle(); RA = {4'd0, 4'd0, 4'd7};
    #2;
    chk("t3_conflict", RD[31:0], 32'h11);
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'hABC; RA = {4'd0, 4'd0, 4'd15};
    #1;
    chk("t3_pc_bypass", RD[31:0], 32'h1000_0008);
    step();
    idle();
    #2;
    chk("t3_pc_after", RD[31:0], 32'h1000_0008);

    // Banked R13 per mode; mode 3 aliases USR.
    Mode = 2'd1; WE3 = 1'b1; A3 = 4'd13; WD3 = 32'h8000;
    step();
    Mode = 2'd2; WD3 = 32'h9000;
    step();
    idle(); RA = {4'd0, 4'd0, 4'd13};
    Mode = 2'd0; #1; chk("t4_usr_empty", RD[31:0], 32'h0);
    Mode = 2'd1; #1; chk("t4_svc", RD[31:0], 32'h8000);
    Mode = 2'd2; #1; chk("t4_irq", RD[31:0], 32'h9000);
    Mode = 2'd3; #1; chk("t4_mode3", RD[31:0], 32'h0);
    step();
    Mode = 2'd3; WE3 = 1'b1; A3 = 4'd13; WD3 = 32'h7000;
    step();
    idle();
    Mode = 2'd0; #1; chk("t4_usr_via_mode3", RD[31:0], 32'h7000);
    Mode = 2'd1; #1; chk("t4_svc_kept", RD[31:0], 32'h8000);

    // Scoreboard set/clear precedence.
    step();
    Mode = 2'd0; RA = {4'd0, 4'd0, 4'd2}; IssueVal = 1'b1; IssueReg = 4'd2;
    #2; chk("t5_not_yet_busy", {31'b0, RBusy[0]}, 32'h0);
    step();
    idle(); #2; chk("t5_busy", {31'b0, RBusy[0]}, 32'h1);
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h55; IssueVal = 1'b1; IssueReg = 4'd2;
    step();
    idle(); #2; chk("t5_set_wins", {31'b0, RBusy[0]}, 32'h1);
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h66;
    #1; chk("t5_clear_pending", {31'b0, RBusy[0]}, 32'h1);
    step();
    idle(); #2; chk("t5_cleared", {31'b0, RBusy[0]}, 32'h0);

    // Issue to PC never sets busy.
    IssueVal = 1'b1; IssueReg = 4'd15; RA = {4'd0, 4'd0, 4'd15};
    step();
    idle(); #2;
    chk("t6_anybusy", {31'b0, AnyBusy}, 32'h0);
    chk("t6_rbusy_pc", {31'b0, RBusy[0]}, 32'h0);

    for (int c = 0; c < 10000; c++) begin
      step();
      Mode     = 2'($urandom_range(0, 3));
      RA       = 12'($urandom);
      R15      = $urandom;
      WE3      = 1'($urandom);
      A3       = 4'($urandom);
      WD3      = $urandom;
      WE4      = 1'($urandom);
      A4       = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom);
      WD4      = $urandom;
      IssueVal = ($urandom_range(0, 2) != 0);
      IssueReg = 4'($urandom);
    end
    step();
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
